// File: rtl/apb_demux_n.sv
// apb_demux_n: single-clock APB 1-to-NUM_SLV demultiplexer.
// Decodes the upstream address against per-slave base/mask pairs, replays the
// transfer on the selected slave from registered request fields, answers
// unmapped addresses with an error, and aborts slaves that stall in ACCESS
// longer than TIMEOUT cycles.
module apb_demux_n #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter logic [NUM_SLV*ADDR_W-1:0] BASE_ADDRS = {
        32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] ADDR_MASKS = {
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [ADDR_W-1:0]         paddr,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_W-1:0]         pwdata,
    input  logic [STRB_W-1:0]         pwstrb,
    output logic                      pready,
    output logic [DATA_W-1:0]         prdata,
    output logic                      pslverr,
    output logic [NUM_SLV-1:0]        m_psel,
    output logic                      m_penable,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic                      m_pwrite,
    output logic [DATA_W-1:0]         m_pwdata,
    output logic [STRB_W-1:0]         m_pwstrb,
    input  logic [NUM_SLV-1:0]        m_pready,
    input  logic [NUM_SLV*DATA_W-1:0] m_prdata,
    input  logic [NUM_SLV-1:0]        m_pslverr,
    output logic [7:0]                err_cnt
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last permitted ACCESS cycle, so that ACCESS
    // lasts exactly TIMEOUT cycles before the abort.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          err_cnt_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                start;
    logic                sel_ready;
    logic                timeout_hit;
    logic                err_event;
    logic [NUM_SLV-1:0]  sel_onehot;
    logic [DATA_W-1:0]   sel_rdata;

    // Address decode: first (lowest-index) matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!hit &&
                ((paddr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
                 (BASE_ADDRS[i*ADDR_W +: ADDR_W] & ADDR_MASKS[i*ADDR_W +: ADDR_W]))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Selected-slave response view and abort/error qualifiers.
    always_comb begin
        sel_onehot        = '0;
        sel_onehot[idx_q] = 1'b1;
        sel_ready         = m_pready[idx_q];
        sel_rdata         = m_prdata[idx_q*DATA_W +: DATA_W];
        start             = (state_q == IDLE) && psel && !penable;
        timeout_hit       = (TIMEOUT != 0) && (cnt_q == TO_LAST);
        err_event         = (start && !hit) ||
                            ((state_q == ACCESS) && !sel_ready && timeout_hit);
    end

    // Transfer state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, response capture and ACCESS wait counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            idx_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= hit_idx;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        wstrb_q <= pwstrb;
                        rdata_q <= '0;
                        err_q   <= !hit;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        err_q   <= m_pslverr[idx_q];
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    cnt_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of decode misses and timeouts.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_cnt_q <= '0;
        end else if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Output drive: slave strobes from state, upstream response only in RESP.
    always_comb begin
        m_psel    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_onehot : '0;
        m_penable = (state_q == ACCESS);
        m_paddr   = addr_q;
        m_pwrite  = write_q;
        m_pwdata  = wdata_q;
        m_pwstrb  = wstrb_q;
        pready    = (state_q == RESP);
        prdata    = (state_q == RESP) ? rdata_q : '0;
        pslverr   = (state_q == RESP) && err_q;
        err_cnt   = err_cnt_q;
    end

endmodule

// File: tb/tb_apb_demux_n.sv
// Scoreboard bench for apb_demux_n: the driver pushes expected responses,
// a negedge monitor pops and compares them whenever pready is seen.
module tb_apb_demux_n;

    logic         pclk = 1'b0;
    logic         presetn;
    logic [31:0]  paddr;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pwstrb;
    logic         pready;
    logic [31:0]  prdata;
    logic         pslverr;
    logic [3:0]   m_psel;
    logic         m_penable;
    logic [31:0]  m_paddr;
    logic         m_pwrite;
    logic [31:0]  m_pwdata;
    logic [3:0]   m_pwstrb;
    logic [3:0]   m_pready;
    logic [127:0] m_prdata;
    logic [3:0]   m_pslverr;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_ecnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        int          issue;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int          wait_cfg[4];
    logic [31:0] rd_cfg[4];
    logic        err_cfg[4];
    int          acc[4];
    logic [3:0]  sel_acc;

    // S3 overlaps S0 for 0x1000_xxxx so lowest-index priority is exercised.
    apb_demux_n #(
        .NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .STRB_W(4),
        .BASE_ADDRS({32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .ADDR_MASKS({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT(8)
    ) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_slv
        assign m_prdata[g*32 +: 32] = rd_cfg[g];
        assign m_pslverr[g]         = err_cfg[g];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave models: ready after wait_cfg ACCESS cycles.
    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_psel[i] && m_penable) begin
                m_pready[i] = (acc[i] == wait_cfg[i]);
                acc[i]      = acc[i] + 1;
            end else begin
                m_pready[i] = 1'b0;
                acc[i]      = 0;
            end
        end
    end

    // Monitor: compare each upstream response with the oldest expectation.
    always @(negedge pclk) begin
        exp_t e;
        if (!presetn) begin
            sel_acc = '0;
        end else begin
            sel_acc = sel_acc | m_psel;
            if (pready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("prdata", prdata, e.rdata);
                    chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                    chk("slave_sel", {28'd0, sel_acc}, {28'd0, e.sel});
                    chk("latency", cyc - e.issue, e.lat);
                end
                sel_acc = '0;
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input logic [3:0] es,
                        input int lat, input bit cnt_err);
        bit got;
        @(posedge pclk); #1;
        paddr = a; pwrite = w; pwdata = wd; pwstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        sb.push_back('{er, ee, es, cyc, lat});
        if (cnt_err && exp_ecnt != 255) exp_ecnt++;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (es != 4'd0) begin
            @(negedge pclk);
            chk("setup_psel", {28'd0, m_psel}, {28'd0, es});
            chk("setup_penable", {31'd0, m_penable}, 32'd0);
            chk("setup_paddr", m_paddr, a);
            chk("setup_pwdata", m_pwdata, wd);
            chk("setup_pwrite", {31'd0, m_pwrite}, {31'd0, w});
            @(negedge pclk);
            chk("access_penable", {31'd0, m_penable}, 32'd1);
            chk("access_psel", {28'd0, m_psel}, {28'd0, es});
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge pclk);
            if (pready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pready_wait actual=timeout required=pready");
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("err_cnt", {24'd0, err_cnt}, exp_ecnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0; rd_cfg[i] = '0; err_cfg[i] = 1'b0; acc[i] = 0;
        end
        m_pready = '0; sel_acc = '0;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pwstrb = '0;
        repeat (3) @(negedge pclk);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_psel", {28'd0, m_psel}, 32'd0);
        chk("rst_penable", {31'd0, m_penable}, 32'd0);
        chk("rst_paddr", m_paddr, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;

        // Zero-wait write to S1.
        xfer(32'h2000_0010, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 4'b0010, 3, 1'b0);
        // S0 read with 3 wait states.
        wait_cfg[0] = 3; rd_cfg[0] = 32'h1234_5678;
        xfer(32'h1000_0100, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 4'b0001, 6, 1'b0);
        // Unmapped read.
        xfer(32'hF000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 1, 1'b1);
        // S2 never ready: abort after 8 ACCESS cycles.
        wait_cfg[2] = 1000; rd_cfg[2] = 32'h7777_7777;
        xfer(32'h3000_0004, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0100, 10, 1'b1);
        // Overlap S0/S3: S0 wins.
        wait_cfg[0] = 0; rd_cfg[0] = 32'h0BAD_F00D; rd_cfg[3] = 32'h3333_3333;
        xfer(32'h1000_0040, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 4'b0001, 3, 1'b0);
        // Slave error passes through, not counted.
        err_cfg[1] = 1'b1; rd_cfg[1] = 32'hDEAD_BEEF;
        xfer(32'h2000_0020, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'b0010, 3, 1'b0);

        // Reset in the middle of ACCESS.
        @(posedge pclk); #1;
        paddr = 32'h3000_0008; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        chk("pre_reset_penable", {31'd0, m_penable}, 32'd1);
        #1 presetn = 1'b0;
        #1;
        chk("mid_rst_psel", {28'd0, m_psel}, 32'd0);
        chk("mid_rst_penable", {31'd0, m_penable}, 32'd0);
        chk("mid_rst_pready", {31'd0, pready}, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        exp_ecnt = 0;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        @(posedge pclk); #1;
        presetn = 1'b1;

        // Normal transfer after reset.
        err_cfg[1] = 1'b0; rd_cfg[1] = 32'h0000_0055;
        xfer(32'h2000_0030, 1'b1, 32'h5A5A_0001, 32'h0000_0055, 1'b0, 4'b0010, 3, 1'b0);

        // Saturation of err_cnt.
        for (int i = 0; i < 300; i++) begin
            xfer(32'h5000_0000 + 32'(i * 4), 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 1, 1'b1);
        end
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        repeat (3) @(negedge pclk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
